// File: rtl/adder_6_check_pkg.sv
// adder_6_check_pkg: shared FSM states and constants for the adder_6 result checker
package adder_6_check_pkg;
  typedef enum logic [1:0] {IDLE, SKIP, CHECK, DONE} state_t;
  localparam int COUT_BIT = 0;
  localparam int SUM0_BIT = 1;
  localparam logic [15:0] NO_ERR = 16'hFFFF;
endpackage

// File: rtl/adder_6_popcount.sv
// adder_6_popcount: combinational count of set bits in a WIDTH-bit vector
module adder_6_popcount #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0]             vec,
  output logic [$clog2(WIDTH+1)-1:0]   count
);
  localparam int CW = $clog2(WIDTH + 1);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CW'(vec[i]);
  end
endmodule

// File: rtl/adder_6_result_checker.sv
// adder_6_result_checker: compares fabric outputs against a reference over a timed run
module adder_6_result_checker
  import adder_6_check_pkg::*;
#(
  parameter int WIDTH        = 7,
  parameter int SKIP_CYCLES  = 1,
  parameter int CHECK_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] gfpga_out,
  input  logic [WIDTH-1:0] bench_out,
  input  logic [WIDTH-1:0] bench_care,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      nb_error,
  output logic [WIDTH-1:0] err_flags,
  output logic [WIDTH-1:0] err_sticky,
  output logic [15:0]      first_err_cycle
);
  localparam int MAXC = (SKIP_CYCLES > CHECK_CYCLES) ? SKIP_CYCLES : CHECK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int PW   = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] nb_error_q, nb_error_d, first_err_q, first_err_d;
  logic [WIDTH-1:0] err_flags_q, err_flags_d, err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0] mismatch, events;
  logic [PW-1:0] ev_cnt;
  logic [16:0] sum;
  logic last_skip, last_check;
  assign mismatch   = (gfpga_out ^ bench_out) & bench_care;
  assign events     = mismatch & ~err_flags_q;
  assign sum        = {1'b0, nb_error_q} + 17'(ev_cnt);
  assign last_skip  = cnt_q == CW'(SKIP_CYCLES - 1);
  assign last_check = cnt_q == CW'(CHECK_CYCLES - 1);
  adder_6_popcount #(.WIDTH(WIDTH)) u_popcount (
    .vec   (events),
    .count (ev_cnt)
  );
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nb_error_d   = nb_error_q;
    err_flags_d  = err_flags_q;
    err_sticky_d = err_sticky_q;
    first_err_d  = first_err_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d      = (SKIP_CYCLES == 0) ? CHECK : SKIP;
        cnt_d        = '0;
        nb_error_d   = '0;
        err_flags_d  = '0;
        err_sticky_d = '0;
        first_err_d  = NO_ERR;
      end
      SKIP: begin
        state_d = last_skip ? CHECK : SKIP;
        cnt_d   = last_skip ? '0 : cnt_q + 1'b1;
      end
      CHECK: begin
        state_d      = last_check ? DONE : CHECK;
        cnt_d        = last_check ? '0 : cnt_q + 1'b1;
        err_flags_d  = last_check ? '0 : mismatch;
        err_sticky_d = err_sticky_q | mismatch;
        nb_error_d   = sum[16] ? NO_ERR : sum[15:0];
        // an empty sticky vector means no mismatch has been seen yet this run
        first_err_d  = (err_sticky_q == '0 && mismatch != '0) ? 16'(cnt_q) : first_err_q;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      nb_error_q   <= '0;
      err_flags_q  <= '0;
      err_sticky_q <= '0;
      first_err_q  <= NO_ERR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nb_error_q   <= nb_error_d;
      err_flags_q  <= err_flags_d;
      err_sticky_q <= err_sticky_d;
      first_err_q  <= first_err_d;
    end
  end
  assign busy            = (state_q == SKIP) || (state_q == CHECK);
  assign done            = state_q == DONE;
  assign pass            = done && (nb_error_q == '0);
  assign nb_error        = nb_error_q;
  assign err_flags       = err_flags_q;
  assign err_sticky      = err_sticky_q;
  assign first_err_cycle = first_err_q;
endmodule

// File: tb/tb_adder_6_result_checker.sv
// tb_adder_6_result_checker: directed table-driven checks of the adder_6 result checker
module tb_adder_6_result_checker;
  logic clk = 1'b0;
  logic reset, start, start2;
  logic [6:0] g, b, care, g2, b2;
  logic busy, done, pass, busy2, done2, pass2;
  logic [15:0] nb, first, nb2, first2;
  logic [6:0] flags, sticky, flags2, sticky2;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0][6:0] mm;
    logic [6:0]      care;
    logic [15:0]     nb;
    logic [6:0]      sticky;
    logic [15:0]     first;
    logic            pass;
  } scn_t;
  scn_t scn [8];

  always #5 clk = ~clk;

  adder_6_result_checker dut (
    .clk(clk), .reset(reset), .start(start), .gfpga_out(g), .bench_out(b), .bench_care(care),
    .busy(busy), .done(done), .pass(pass), .nb_error(nb), .err_flags(flags),
    .err_sticky(sticky), .first_err_cycle(first)
  );

  adder_6_result_checker #(.CHECK_CYCLES(70000)) dut_sat (
    .clk(clk), .reset(reset), .start(start2), .gfpga_out(g2), .bench_out(b2), .bench_care(7'h7F),
    .busy(busy2), .done(done2), .pass(pass2), .nb_error(nb2), .err_flags(flags2),
    .err_sticky(sticky2), .first_err_cycle(first2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " nb_error"}, nb, 0);
    chk({tag, " err_flags"}, flags, 0);
    chk({tag, " err_sticky"}, sticky, 0);
    chk({tag, " first_err"}, first, 16'hFFFF);
  endtask

  task automatic run_scn(input int id, input int restart_c);
    scn_t s = scn[id];
    logic [6:0] base = 7'(id * 13 + 5);
    @(negedge clk);
    start = 1'b1; b = base; care = s.care; g = base ^ 7'h7F;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      start = (c == restart_c);
      chk($sformatf("scn%0d c%0d busy", id, c), busy, 1);
      chk($sformatf("scn%0d c%0d done", id, c), done, 0);
      if (c >= 2) chk($sformatf("scn%0d c%0d err_flags", id, c), flags, s.mm[c-2] & s.care);
      g = (c == 0) ? base ^ 7'h7F : base ^ s.mm[c-1];
    end
    @(negedge clk);
    g = base;
    chk($sformatf("scn%0d busy_end", id), busy, 0);
    chk($sformatf("scn%0d done", id), done, 1);
    chk($sformatf("scn%0d pass", id), pass, s.pass);
    chk($sformatf("scn%0d nb_error", id), nb, s.nb);
    chk($sformatf("scn%0d err_sticky", id), sticky, s.sticky);
    chk($sformatf("scn%0d first_err", id), first, s.first);
    chk($sformatf("scn%0d err_flags_done", id), flags, 0);
    @(negedge clk);
    chk($sformatf("scn%0d done_hold", id), done, 1);
    chk($sformatf("scn%0d nb_hold", id), nb, s.nb);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      scn[i] = '0;
      scn[i].care = 7'h7F;
      scn[i].first = 16'hFFFF;
      scn[i].pass = 1'b1;
    end
    for (int k = 2; k <= 4; k++) scn[1].mm[k] = 7'h08;
    scn[1].nb = 1; scn[1].sticky = 7'h08; scn[1].first = 2; scn[1].pass = 0;
    scn[2].mm[0] = 7'h41; scn[2].mm[5] = 7'h01;
    scn[2].nb = 3; scn[2].sticky = 7'h41; scn[2].first = 0; scn[2].pass = 0;
    for (int k = 0; k < 10; k++) scn[3].mm[k] = 7'h02;
    scn[3].care = 7'h7D;
    for (int k = 0; k < 10; k++) scn[4].mm[k] = 7'h7F;
    scn[4].nb = 7; scn[4].sticky = 7'h7F; scn[4].first = 0; scn[4].pass = 0;
    for (int k = 1; k < 10; k += 2) scn[5].mm[k] = 7'h04;
    scn[5].nb = 5; scn[5].sticky = 7'h04; scn[5].first = 1; scn[5].pass = 0;
    scn[6].mm[9] = 7'h20;
    scn[6].nb = 1; scn[6].sticky = 7'h20; scn[6].first = 9; scn[6].pass = 0;
    scn[7].mm[8] = 7'h03; scn[7].mm[9] = 7'h06;
    scn[7].nb = 3; scn[7].sticky = 7'h07; scn[7].first = 8; scn[7].pass = 0;

    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    g = '0; b = '0; care = 7'h7F; g2 = '0; b2 = 7'h2A;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset sat busy", busy2, 0);
    chk("reset sat nb", nb2, 0);
    chk("reset sat first", first2, 16'hFFFF);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    for (int i = 0; i < 8; i++) run_scn(i, (i == 1) ? 5 : -1);

    // abort a run by reset during CHECK index 4 after two error events
    start = 1'b1; b = 7'h11; care = 7'h7F; g = 7'h11 ^ 7'h7F;
    @(negedge clk); start = 1'b0;
    @(negedge clk); g = 7'h11 ^ 7'h01;
    @(negedge clk); g = 7'h11 ^ 7'h02;
    @(negedge clk); g = 7'h11;
    chk("abort nb_before", nb, 2);
    chk("abort first_before", first, 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk_idle("abort");
    run_scn(0, -1);

    // saturation: all bits mismatch on every even CHECK index of a 70000-cycle run
    start2 = 1'b1; g2 = b2 ^ 7'h7F;
    for (int c = 0; c <= 70000; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      g2 = b2 ^ ((c % 2 == 1) ? 7'h7F : 7'h00);
      if (c == 20) chk("sat nb_early", nb2, 7 * 10);
      if (c == 70000) begin
        chk("sat busy_last", busy2, 1);
        chk("sat done_last", done2, 0);
      end
    end
    @(negedge clk);
    chk("sat done", done2, 1);
    chk("sat nb_error", nb2, 16'hFFFF);
    chk("sat pass", pass2, 0);
    chk("sat sticky", sticky2, 7'h7F);
    chk("sat first", first2, 0);
    chk("sat flags", flags2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_6_result_checker.md
ADDER_6_RESULT_CHECKER -- requirements
Module: adder_6_result_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 7, giving the compared output vector width (bit 0 = cout, bits 1..6 = sum_0..sum_5).
REQ-002 The block SHALL have parameter SKIP_CYCLES, default 1, giving the initialization cycles ignored after start.
REQ-003 The block SHALL have parameter CHECK_CYCLES, default 10, giving the number of compared cycles per run.
REQ-004 Port clk, input, 1: single clock; every register samples on the rising edge.
REQ-005 Port reset, input, 1: reset; synchronous, active-high.
REQ-006 Port start, input, 1: one-cycle run request.
REQ-007 Port gfpga_out, input, WIDTH: fabric outputs under test.
REQ-008 Port bench_out, input, WIDTH: reference benchmark outputs.
REQ-009 Port bench_care, input, WIDTH: per-bit compare enable; 0 = reference unknown, never a mismatch.
REQ-010 Port busy, output, 1: run in progress (SKIP or CHECK).
REQ-011 Port done, output, 1: run finished; held until next run or reset.
REQ-012 Port pass, output, 1: done and nb_error == 0.
REQ-013 Port nb_error, output, 16: saturating mismatch-event count.
REQ-014 Port err_flags, output, WIDTH: registered per-bit mismatch flags of the last compared cycle.
REQ-015 Port err_sticky, output, WIDTH: per-bit OR of all mismatches this run.
REQ-016 Port first_err_cycle, output, 16: 0-based CHECK index of first mismatch; 16'hFFFF if none.

Function
REQ-017 FSM states SHALL be IDLE, SKIP, CHECK, DONE.
REQ-018 IDLE or DONE with start=1 SHALL go to SKIP, or to CHECK when SKIP_CYCLES=0, clearing nb_error, err_flags and err_sticky, and setting first_err_cycle to 16'hFFFF on that edge.
REQ-019 SKIP SHALL last exactly SKIP_CYCLES cycles, then go to CHECK; inputs are not compared in SKIP.
REQ-020 CHECK SHALL last exactly CHECK_CYCLES cycles, then go to DONE.
REQ-021 start SHALL be ignored in SKIP and CHECK.
REQ-022 Per CHECK cycle: mismatch = (gfpga_out ^ bench_out) & bench_care; err_flags SHALL be loaded with mismatch on that edge.
REQ-023 A mismatch event SHALL be a per-bit 0->1 transition, i.e. mismatch & ~err_flags; consecutive mismatching cycles on one bit count once.
REQ-024 nb_error SHALL add the popcount of mismatch events in the same edge as the err_flags update, saturating at 16'hFFFF.
REQ-025 On the first CHECK cycle, err_flags holds 0 from the clear, so any mismatch there counts.
REQ-026 first_err_cycle SHALL capture the CHECK index on the first cycle with nonzero mismatch and SHALL then hold.
REQ-027 err_flags SHALL clear to 0 on entry to DONE; err_sticky and nb_error SHALL hold in DONE.
REQ-028 busy SHALL be 1 exactly in SKIP and CHECK; done SHALL be 1 exactly in DONE; pass = done & (nb_error == 0); all three are registered or derived from the state register only.
REQ-029 A run SHALL take SKIP_CYCLES + CHECK_CYCLES cycles from the start edge to done=1; done rises the edge after the last compare.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, busy=0, done=0, pass=0, nb_error=0, err_flags=0, err_sticky=0, and first_err_cycle=16'hFFFF.
REQ-031 reset SHALL take priority over start and over any run in progress; a reset mid-run aborts the run with no partial results retained.

Structure
REQ-032 Package adder_6_check_pkg SHALL hold the state enum, the bit-index constants (COUT_BIT=0, SUM0_BIT=1) and NO_ERR=16'hFFFF.
REQ-033 Sub-module adder_6_popcount, parameterized by WIDTH and purely combinational, SHALL compute the event count.
REQ-034 Phase counters SHALL be sized with $clog2 of max(SKIP_CYCLES, CHECK_CYCLES) + 1.

Verification
REQ-035 Defaults, gfpga_out==bench_out, care all-ones, start pulse -> busy for 11 cycles, done=1, pass=1, nb_error=0, first_err_cycle=16'hFFFF.
REQ-036 Bit 3 mismatching in CHECK cycles 2-4 only -> nb_error=1, err_sticky=7'b0001000, first_err_cycle=2.
REQ-037 Bits 0 and 6 mismatching in CHECK cycle 0, then bit 0 again in cycle 5 -> nb_error=3, first_err_cycle=0, pass=0.
REQ-038 Mismatch on bit 1 with bench_care[1]=0 for the whole run -> nb_error=0, pass=1.
REQ-039 reset asserted in CHECK cycle 4 after 2 errors -> next cycle IDLE, nb_error=0, done=0; a following start runs cleanly.
REQ-040 start pulsed mid-CHECK is ignored (done still at cycle 11); CHECK_CYCLES=70000 with a toggling all-bits mismatch -> nb_error saturates at 16'hFFFF.
